// File: rtl/wma_calculator.sv
// Weighted moving average update with adaptive band thresholds.
// One-cycle latency; every input qualified by in_valid yields one registered result.
module wma_calculator (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] x,
    input  logic [7:0] WMA0,
    input  logic [1:0] threshold_select,
    output logic [7:0] T1,
    output logic [7:0] T2,
    output logic [7:0] WMA1,
    output logic       out_valid
);

    logic [7:0]  p;
    logic [15:0] prod;
    logic [7:0]  delta;
    logic [8:0]  sum9;
    logic [7:0]  t1_d;
    logic [7:0]  t2_d;
    logic        in_band;
    logic [9:0]  acc10;
    logic [10:0] acc11;
    logic [7:0]  wma1_d;
    logic        unused_low_bits;

    always_comb begin
        p = 8'd32;
        case (threshold_select)
            2'b00:   p = 8'd32;
            2'b01:   p = 8'd64;
            2'b10:   p = 8'd128;
            default: p = 8'd32;
        endcase
    end

    assign prod  = {8'd0, WMA0} * {8'd0, p};
    assign delta = prod[15:8];

    assign sum9 = {1'b0, WMA0} + {1'b0, delta};
    assign t1_d = (WMA0 >= delta) ? (WMA0 - delta) : 8'd0;
    assign t2_d = sum9[8] ? 8'hFF : sum9[7:0];

    assign in_band = (x >= t1_d) && (x <= t2_d);

    // 3*W as W + 2*W; 7*W as 8*W - W (never negative since 8*W >= W)
    assign acc10 = {2'b00, x} + {2'b00, WMA0} + {1'b0, WMA0, 1'b0};
    assign acc11 = {3'b000, x} + ({WMA0, 3'b000} - {3'b000, WMA0});

    assign wma1_d = in_band ? acc10[9:2] : acc11[10:3];

    assign unused_low_bits = ^{prod[7:0], acc10[1:0], acc11[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            T1        <= 8'd0;
            T2        <= 8'd0;
            WMA1      <= 8'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                T1   <= t1_d;
                T2   <= t2_d;
                WMA1 <= wma1_d;
            end
        end
    end

endmodule

// File: tb/tb_wma_calculator.sv
// Scoreboard bench for wma_calculator: directed vectors pushed as expectations,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_wma_calculator;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] x;
    logic [7:0] WMA0;
    logic [1:0] threshold_select;
    logic [7:0] T1;
    logic [7:0] T2;
    logic [7:0] WMA1;
    logic       out_valid;

    typedef struct packed {
        logic [7:0] t1;
        logic [7:0] t2;
        logic [7:0] wma;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   checks = 0;
    int   errors = 0;

    wma_calculator dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .x                (x),
        .WMA0             (WMA0),
        .threshold_select (threshold_select),
        .T1               (T1),
        .T2               (T2),
        .WMA1             (WMA1),
        .out_valid        (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare each presented result against the oldest expectation
    always @(negedge clk) begin
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid got T1=%0d T2=%0d WMA1=%0d expected none",
                         T1, T2, WMA1);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({T1, T2, WMA1} !== e) begin
                    errors++;
                    $display("FAIL result got T1=%0d T2=%0d WMA1=%0d expected T1=%0d T2=%0d WMA1=%0d",
                             T1, T2, WMA1, e.t1, e.t2, e.wma);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    // Presents one valid sample for the next rising edge
    task automatic send(input logic [1:0] sel, input logic [7:0] xv, input logic [7:0] w,
                        input logic [7:0] t1, input logic [7:0] t2, input logic [7:0] wma);
        exp_t e;
        e = '{t1: t1, t2: t2, wma: wma};
        in_valid         = 1'b1;
        threshold_select = sel;
        x                = xv;
        WMA0             = w;
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [7:0] xv, input logic [7:0] w, input logic [1:0] sel);
        in_valid         = 1'b0;
        x                = xv;
        WMA0             = w;
        threshold_select = sel;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        in_valid         = 1'b0;
        x                = 8'd0;
        WMA0             = 8'd0;
        threshold_select = 2'b00;
        last_exp         = '0;

        #2;
        check("reset_T1", {24'd0, T1}, 32'd0);
        check("reset_T2", {24'd0, T2}, 32'd0);
        check("reset_WMA1", {24'd0, WMA1}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back directed vectors
        send(2'b00, 8'd50,  8'd60,  8'd53,  8'd67,  8'd58);
        send(2'b01, 8'd85,  8'd75,  8'd57,  8'd93,  8'd77);
        send(2'b00, 8'd255, 8'd255, 8'd224, 8'd255, 8'd255);
        send(2'b10, 8'd30,  8'd200, 8'd100, 8'd255, 8'd178);
        send(2'b11, 8'd62,  8'd60,  8'd53,  8'd67,  8'd60);
        send(2'b00, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0);
        send(2'b01, 8'd100, 8'd255, 8'd192, 8'd255, 8'd235);
        send(2'b10, 8'd0,   8'd1,   8'd1,   8'd1,   8'd0);
        send(2'b00, 8'd1,   8'd1,   8'd1,   8'd1,   8'd1);

        // Inputs wander with in_valid low: outputs must hold
        for (int i = 0; i < 3; i++) begin
            idle(8'(40 + 70 * i), 8'(90 + 50 * i), 2'(i));
            check("hold_out_valid", {31'd0, out_valid}, 32'd0);
            check("hold_T1", {24'd0, T1}, {24'd0, last_exp.t1});
            check("hold_T2", {24'd0, T2}, {24'd0, last_exp.t2});
            check("hold_WMA1", {24'd0, WMA1}, {24'd0, last_exp.wma});
        end

        // Reset mid-stream: the sample presented under reset is discarded
        send(2'b01, 8'd85, 8'd75, 8'd57, 8'd93, 8'd77);
        idle(8'd5, 8'd6, 2'b11);
        in_valid         = 1'b1;
        threshold_select = 2'b10;
        x                = 8'd30;
        WMA0             = 8'd200;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_T1", {24'd0, T1}, 32'd0);
        check("async_rst_T2", {24'd0, T2}, 32'd0);
        check("async_rst_WMA1", {24'd0, WMA1}, 32'd0);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        check("post_rst_WMA1", {24'd0, WMA1}, 32'd0);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        send(2'b00, 8'd50, 8'd60, 8'd53, 8'd67, 8'd58);
        idle(8'd0, 8'd0, 2'b00);
        check("single_pulse_out_valid", {31'd0, out_valid}, 32'd0);

        idle(8'd0, 8'd0, 2'b00);
        idle(8'd0, 8'd0, 2'b00);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/wma_calculator.md
WMA_CALCULATOR -- requirements
Module: wma_calculator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 in_valid  input  1  qualifies x, WMA0 and threshold_select for one cycle.
REQ-005 x  input  8  new unsigned temperature sample.
REQ-006 WMA0  input  8  previous unsigned weighted moving average.
REQ-007 threshold_select  input  2  band-width select.
REQ-008 T1  output  8  lower band threshold, registered.
REQ-009 T2  output  8  upper band threshold, registered.
REQ-010 WMA1  output  8  updated weighted moving average, registered.
REQ-011 out_valid  output  1  high for exactly one cycle when T1, T2 and WMA1 are updated.

Function
REQ-012 Band factor P SHALL be:
- 32 for threshold_select 00;
- 64 for 01;
- 128 for 10;
- 32 for 11 (default).
REQ-013 delta SHALL equal floor(WMA0*P/256), computed at 16-bit width without overflow; range 0..127.
REQ-014 T1 SHALL equal WMA0 - delta, saturating at 0.
REQ-015 T2 SHALL equal WMA0 + delta, computed at 9-bit width and saturating at 255.
REQ-016 x SHALL be in-band when T1 <= x <= T2 (both bounds inclusive, unsigned compare).
REQ-017 In-band: WMA1 SHALL equal floor((x + 3*WMA0)/4), with a 10-bit intermediate.
REQ-018 Out-of-band: WMA1 SHALL equal floor((x + 7*WMA0)/8), with an 11-bit intermediate.
REQ-019 Rounding SHALL be truncation only; the result SHALL always fit in 8 bits with no saturation needed.
REQ-020 On a rising clk edge with in_valid=1:
- T1, T2 and WMA1 SHALL be loaded from the current inputs;
- out_valid SHALL be 1 in the following cycle;
- latency is exactly 1 cycle.
REQ-021 On a rising clk edge with in_valid=0:
- T1, T2 and WMA1 SHALL hold their values;
- out_valid SHALL be 0.
REQ-022 Back-to-back in_valid SHALL be accepted every cycle, giving one result per cycle; there is no back-pressure.
REQ-023 An input change without in_valid SHALL NOT affect the outputs.

Reset
REQ-024 While rst=1, T1, T2, WMA1 and out_valid SHALL be 0 immediately, independent of clk.
REQ-025 When rst is asserted mid-stream, the in-flight result SHALL be discarded.
REQ-026 After rst deasserts, the first valid sample SHALL produce a normal result 1 cycle later.

Verification
REQ-027 Out-of-band case: sel=00, x=50, WMA0=60 -> T1=53, T2=67, WMA1=58, out_valid pulse.
REQ-028 In-band case: sel=01, x=85, WMA0=75 -> T1=57, T2=93, WMA1=77.
REQ-029 Saturation cases:
- sel=00, x=255, WMA0=255 -> T1=224, T2=255 (saturated), WMA1=255;
- sel=10, x=30, WMA0=200 -> T1=100, T2=255, WMA1=178.
REQ-030 Default select and zero-input cases:
- sel=11, x=62, WMA0=60 -> T1=53, T2=67, WMA1=60;
- sel=00, x=0, WMA0=0 -> T1=0, T2=0, WMA1=0 (in-band at equality).
REQ-031 Valid gating: inputs change with in_valid=0 -> outputs hold, out_valid=0.
REQ-032 Reset mid-stream: rst pulsed between two valid samples -> outputs go to 0 asynchronously, and the next valid sample yields its correct result.
